// File: rtl/key_debounce_scheduler_pkg.sv
// Shared types and defaults for the synth key front-end controller.
package synth_ctrl_pkg;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        TIMING = 2'd1,
        PUSH   = 2'd2
    } kds_state_t;

    localparam int DEFAULT_DEBOUNCE_THRESHOLD = 15000;

endpackage

// File: rtl/key_debounce_scheduler_event_fifo.sv
// Show-ahead event FIFO; writes are refused while full, reads while empty.
module event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; occupancy above decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/key_debounce_scheduler.sv
// Debounces NUM_KEYS raw keys with one round-robin shared timer and queues
// press/release events for the voice controller.
module key_debounce_scheduler
    import synth_ctrl_pkg::*;
#(
    parameter int NUM_KEYS           = 8,
    parameter int DEBOUNCE_THRESHOLD = DEFAULT_DEBOUNCE_THRESHOLD,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         raw_keys,
    output logic [NUM_KEYS-1:0]         key_state,
    output logic                        event_valid,
    output logic                        event_press,
    output logic [$clog2(NUM_KEYS)-1:0] event_key,
    input  logic                        event_ready,
    output logic                        busy
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int CW = $clog2(DEBOUNCE_THRESHOLD + 1);
    localparam int EW = KW + 1;

    function automatic logic [KW-1:0] next_key(input logic [KW-1:0] k);
        return (k == KW'(NUM_KEYS - 1)) ? '0 : k + 1'b1;
    endfunction

    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;
    kds_state_t          state;
    kds_state_t          next_state;
    logic [KW-1:0]       ptr;
    logic [KW-1:0]       cur;
    logic [CW-1:0]       counter;
    logic                fifo_wr;
    logic                fifo_full;
    logic                fifo_empty;
    logic [EW-1:0]       wr_data;
    logic [EW-1:0]       rd_data;

    // Stage p0/p1: two-flop synchronizer on the asynchronous key pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_keys;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SCAN;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SCAN:    if (sync_p1[ptr] != key_state[ptr]) next_state = TIMING;
            TIMING: begin
                if (sync_p1[cur] == key_state[cur])                next_state = SCAN;
                else if (counter == CW'(DEBOUNCE_THRESHOLD - 1))   next_state = PUSH;
            end
            PUSH:    if (!fifo_full) next_state = SCAN;
            default: next_state = SCAN;
        endcase
    end

    always_comb begin
        busy    = (state == TIMING) || (state == PUSH);
        fifo_wr = (state == PUSH) && !fifo_full;
        wr_data = {~key_state[cur], cur};
    end

    // The timer belongs to key cur until it either bounces back or commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            cur       <= '0;
            counter   <= '0;
            key_state <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (sync_p1[ptr] != key_state[ptr]) begin
                        cur     <= ptr;
                        counter <= '0;
                    end else begin
                        ptr <= next_key(ptr);
                    end
                end
                TIMING: begin
                    if (sync_p1[cur] == key_state[cur])
                        ptr <= next_key(cur);
                    else if (counter != CW'(DEBOUNCE_THRESHOLD - 1))
                        counter <= counter + 1'b1;
                end
                PUSH: begin
                    if (!fifo_full) begin
                        key_state[cur] <= ~key_state[cur];
                        ptr            <= next_key(cur);
                    end
                end
                default: ;
            endcase
        end
    end

    event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_data),
        .full    (fifo_full),
        .rd_en   (event_ready),
        .rd_data (rd_data),
        .empty   (fifo_empty)
    );

    // Head fields are forced to zero when empty so stale storage never shows.
    assign event_valid = !fifo_empty;
    assign event_press = event_valid ? rd_data[KW] : 1'b0;
    assign event_key   = event_valid ? rd_data[KW-1:0] : '0;

endmodule
